// File: rtl/core_pkg.sv
// Shared RV32I core definitions: datapath widths, register x0, ALU op codes
// and the packed control bundle that travels down the pipeline.
package core_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ALUOP_W = 4;
    localparam int unsigned REG_W   = 5;

    localparam logic [REG_W-1:0] REG_X0 = 5'd0;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'd5;
    localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'd8;
    localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'd9;

    typedef struct packed {
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               alu_src;
        logic               branch;
        logic               jump;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/wb_operand_bypass.sv
// Selects WB write data over a register-file/held operand when WB targets the
// same non-x0 register in this cycle.
module wb_operand_bypass
    import core_pkg::*;
(
    input  logic [REG_W-1:0] i_index,
    input  logic [XLEN-1:0]  i_data,
    input  logic             i_wb_reg_write,
    input  logic [REG_W-1:0] i_wb_rd,
    input  logic [XLEN-1:0]  i_wb_data,
    output logic [XLEN-1:0]  o_data_c
);

    logic w_hit;

    assign w_hit    = i_wb_reg_write && (i_wb_rd != REG_X0) && (i_wb_rd == i_index);
    assign o_data_c = w_hit ? i_wb_data : i_data;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall hold, flush bubble insertion, WB
// write-through on capture and WB refresh of held operands.
module id_ex_pipe_reg
    import core_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [REG_W-1:0]   id_rs1,
    input  logic [REG_W-1:0]   id_rs2,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_mem_to_reg,
    input  logic               id_alu_src,
    input  logic               id_branch,
    input  logic               id_jump,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               wb_reg_write,
    input  logic [REG_W-1:0]   wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic               id_ex_valid,
    output logic [XLEN-1:0]    id_ex_pc,
    output logic [XLEN-1:0]    id_ex_rs1_data,
    output logic [XLEN-1:0]    id_ex_rs2_data,
    output logic [XLEN-1:0]    id_ex_imm,
    output logic [REG_W-1:0]   id_ex_rs1,
    output logic [REG_W-1:0]   id_ex_rs2,
    output logic [REG_W-1:0]   id_ex_rd,
    output logic               id_ex_reg_write,
    output logic               id_ex_mem_read,
    output logic               id_ex_mem_write,
    output logic               id_ex_mem_to_reg,
    output logic               id_ex_alu_src,
    output logic               id_ex_branch,
    output logic               id_ex_jump,
    output logic [ALUOP_W-1:0] id_ex_alu_op,
    output logic [CNT_W-1:0]   bubble_cnt
);

    logic               r_valid;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_rs1_data;
    logic [XLEN-1:0]    r_rs2_data;
    logic [XLEN-1:0]    r_imm;
    logic [REG_W-1:0]   r_rs1;
    logic [REG_W-1:0]   r_rs2;
    logic [REG_W-1:0]   r_rd;
    ctrl_t              r_ctrl;
    logic [CNT_W-1:0]   r_bubble_cnt;

    ctrl_t              w_id_ctrl;
    logic [REG_W-1:0]   w_sel_rs1;
    logic [REG_W-1:0]   w_sel_rs2;
    logic [XLEN-1:0]    w_sel_rs1_data;
    logic [XLEN-1:0]    w_sel_rs2_data;
    logic               w_wb_en;
    logic [XLEN-1:0]    w_rs1_data;
    logic [XLEN-1:0]    w_rs2_data;

    assign w_id_ctrl = '{reg_write:  id_reg_write,
                         mem_read:   id_mem_read,
                         mem_write:  id_mem_write,
                         mem_to_reg: id_mem_to_reg,
                         alu_src:    id_alu_src,
                         branch:     id_branch,
                         jump:       id_jump,
                         alu_op:     id_alu_op};

    // One bypass per operand: compares against the incoming index on capture
    // and against the held index on stall; a held bubble is never refreshed.
    assign w_sel_rs1      = stall ? r_rs1      : id_rs1;
    assign w_sel_rs2      = stall ? r_rs2      : id_rs2;
    assign w_sel_rs1_data = stall ? r_rs1_data : id_rs1_data;
    assign w_sel_rs2_data = stall ? r_rs2_data : id_rs2_data;
    assign w_wb_en        = wb_reg_write && (!stall || r_valid);

    wb_operand_bypass u_bypass_rs1 (
        .i_index        (w_sel_rs1),
        .i_data         (w_sel_rs1_data),
        .i_wb_reg_write (w_wb_en),
        .i_wb_rd        (wb_rd),
        .i_wb_data      (wb_data),
        .o_data_c       (w_rs1_data)
    );

    wb_operand_bypass u_bypass_rs2 (
        .i_index        (w_sel_rs2),
        .i_data         (w_sel_rs2_data),
        .i_wb_reg_write (w_wb_en),
        .i_wb_rd        (wb_rd),
        .i_wb_data      (wb_data),
        .o_data_c       (w_rs2_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_rs1        <= REG_X0;
            r_rs2        <= REG_X0;
            r_rd         <= REG_X0;
            r_ctrl       <= CTRL_BUBBLE;
            r_bubble_cnt <= '0;
        end else if (flush) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_rs1        <= REG_X0;
            r_rs2        <= REG_X0;
            r_rd         <= REG_X0;
            r_ctrl       <= CTRL_BUBBLE;
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end else if (!stall) begin
            r_valid      <= id_valid;
            r_pc         <= id_pc;
            r_rs1_data   <= w_rs1_data;
            r_rs2_data   <= w_rs2_data;
            r_imm        <= id_imm;
            r_rs1        <= id_rs1;
            r_rs2        <= id_rs2;
            r_rd         <= id_rd;
            r_ctrl       <= id_valid ? w_id_ctrl : CTRL_BUBBLE;
        end else begin
            r_rs1_data   <= w_rs1_data;
            r_rs2_data   <= w_rs2_data;
        end
    end

    assign id_ex_valid      = r_valid;
    assign id_ex_pc         = r_pc;
    assign id_ex_rs1_data   = r_rs1_data;
    assign id_ex_rs2_data   = r_rs2_data;
    assign id_ex_imm        = r_imm;
    assign id_ex_rs1        = r_rs1;
    assign id_ex_rs2        = r_rs2;
    assign id_ex_rd         = r_rd;
    assign id_ex_reg_write  = r_ctrl.reg_write;
    assign id_ex_mem_read   = r_ctrl.mem_read;
    assign id_ex_mem_write  = r_ctrl.mem_write;
    assign id_ex_mem_to_reg = r_ctrl.mem_to_reg;
    assign id_ex_alu_src    = r_ctrl.alu_src;
    assign id_ex_branch     = r_ctrl.branch;
    assign id_ex_jump       = r_ctrl.jump;
    assign id_ex_alu_op     = r_ctrl.alu_op;
    assign bubble_cnt       = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: directed scenarios plus random traffic,
// expected state computed by a behavioural model of the register's rules.
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic        rst;
        logic        flush;
        logic        stall;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  ctl;   // reg_write,mem_read,mem_write,mem_to_reg,alu_src,branch,jump
        logic [3:0]  op;
        logic        wbw;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  ctl;
        logic [3:0]  op;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        id_alu_src, id_branch, id_jump, wb_reg_write;
    logic [3:0]  id_alu_op;

    logic        id_ex_valid;
    logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
    logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg;
    logic        id_ex_alu_src, id_ex_branch, id_ex_jump;
    logic [3:0]  id_ex_alu_op;
    logic [15:0] bubble_cnt;

    exp_t  w_act;
    exp_t  model;
    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_branch(id_branch),
        .id_jump(id_jump), .id_alu_op(id_alu_op),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc), .id_ex_rs1_data(id_ex_rs1_data),
        .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_mem_write(id_ex_mem_write), .id_ex_mem_to_reg(id_ex_mem_to_reg),
        .id_ex_alu_src(id_ex_alu_src), .id_ex_branch(id_ex_branch), .id_ex_jump(id_ex_jump),
        .id_ex_alu_op(id_ex_alu_op), .bubble_cnt(bubble_cnt)
    );

    assign w_act = {id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
                    id_ex_rs1, id_ex_rs2, id_ex_rd,
                    id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg,
                    id_ex_alu_src, id_ex_branch, id_ex_jump, id_ex_alu_op, bubble_cnt};

    // Reference: what the ID/EX register must hold after one edge.
    function automatic exp_t step(input exp_t cur, input stim_t s);
        exp_t n;
        n = cur;
        if (s.rst) begin
            n = '0;
        end else if (s.flush) begin
            n     = '0;
            n.cnt = cur.cnt + 16'd1;
        end else if (s.stall) begin
            if (cur.valid && s.wbw && s.wbrd != 5'd0) begin
                if (s.wbrd == cur.rs1) n.d1 = s.wbd;
                if (s.wbrd == cur.rs2) n.d2 = s.wbd;
            end
        end else begin
            n.valid = s.valid;
            n.pc    = s.pc;
            n.imm   = s.imm;
            n.rs1   = s.rs1;
            n.rs2   = s.rs2;
            n.rd    = s.rd;
            n.d1    = (s.wbw && s.wbrd != 5'd0 && s.wbrd == s.rs1) ? s.wbd : s.d1;
            n.d2    = (s.wbw && s.wbrd != 5'd0 && s.wbrd == s.rs2) ? s.wbd : s.d2;
            n.ctl   = s.valid ? s.ctl : 7'd0;
            n.op    = s.valid ? s.op  : 4'd0;
        end
        return n;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.rst   = 1'b0;
        s.flush = 1'b0;
        s.stall = 1'b0;
        s.valid = 1'($urandom);
        s.pc    = $urandom;
        s.d1    = $urandom;
        s.d2    = $urandom;
        s.imm   = $urandom;
        s.rs1   = 5'($urandom);
        s.rs2   = 5'($urandom);
        s.rd    = 5'($urandom);
        s.ctl   = 7'($urandom);
        s.op    = 4'($urandom);
        s.wbw   = 1'($urandom);
        s.wbrd  = 5'($urandom);
        s.wbd   = $urandom;
        return s;
    endfunction

    task automatic apply(input stim_t s, input string tag);
        @(negedge clk);
        rst = s.rst; flush = s.flush; stall = s.stall; id_valid = s.valid;
        id_pc = s.pc; id_rs1_data = s.d1; id_rs2_data = s.d2; id_imm = s.imm;
        id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
        {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
         id_alu_src, id_branch, id_jump} = s.ctl;
        id_alu_op = s.op; wb_reg_write = s.wbw; wb_rd = s.wbrd; wb_data = s.wbd;
        model = step(model, s);
        exp_q.push_back(model);
        tag_q.push_back(tag);
        @(posedge clk);
    endtask

    // Monitor: the register presents a new entry after every edge.
    initial begin
        exp_t  e;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                n_cmp++;
                if (w_act !== e) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", t, w_act, e);
                end
            end
        end
    end

    initial begin
        stim_t s;
        int    wait_cyc;
        model = '0;

        s = rnd(); s.rst = 1'b1; s.stall = 1'b1; s.flush = 1'b1;
        apply(s, "reset");

        s = rnd(); s.valid = 1'b1; s.pc = 32'h100; s.rs1 = 5'd5; s.rs2 = 5'd6; s.rd = 5'd7;
        s.ctl[6] = 1'b1; s.d1 = 32'hAAAA; s.wbw = 1'b0;
        apply(s, "load_basic");

        s = rnd(); s.valid = 1'b1; s.rs1 = 5'd5; s.d1 = 32'h1;
        s.wbw = 1'b1; s.wbrd = 5'd5; s.wbd = 32'h55;
        apply(s, "wb_through");

        s = rnd(); s.valid = 1'b1; s.rs1 = 5'd0; s.d1 = 32'h1;
        s.wbw = 1'b1; s.wbrd = 5'd0; s.wbd = 32'h55;
        apply(s, "x0_no_bypass");

        s = rnd(); s.valid = 1'b1; s.rs1 = 5'd9; s.rs2 = 5'd9; s.d1 = 32'h3; s.d2 = 32'h4;
        s.wbw = 1'b1; s.wbrd = 5'd9; s.wbd = 32'h99;
        apply(s, "wb_both_ops");

        s = rnd(); s.valid = 1'b1; s.rs1 = 5'd3; s.rs2 = 5'd9; s.wbw = 1'b0;
        apply(s, "hold_load");
        for (int i = 0; i < 3; i++) begin
            s = rnd(); s.stall = 1'b1;
            s.wbw  = (i == 1);
            s.wbrd = (i == 1) ? 5'd9 : 5'd3;
            s.wbd  = 32'h77;
            apply(s, "stall_refresh");
        end

        s = rnd(); s.valid = 1'b0; s.rs1 = 5'd4; s.wbw = 1'b0;
        apply(s, "invalid_load");
        s = rnd(); s.stall = 1'b1; s.wbw = 1'b1; s.wbrd = 5'd4; s.wbd = 32'hDEAD;
        apply(s, "no_refresh_invalid");

        s = rnd(); s.flush = 1'b1; s.stall = 1'b1;
        apply(s, "flush_stall");
        for (int i = 0; i < 65534; i++) begin
            s = rnd(); s.flush = 1'b1; s.stall = 1'($urandom);
            apply(s, "flush_fill");
        end
        s = rnd(); s.flush = 1'b1;
        apply(s, "cnt_wrap");
        s = rnd(); s.flush = 1'b1;
        apply(s, "cnt_after_wrap");

        s = rnd(); s.valid = 1'b1; s.wbw = 1'b0;
        apply(s, "pre_rst_load");
        s = rnd(); s.stall = 1'b1;
        apply(s, "pre_rst_stall");
        s = rnd(); s.stall = 1'b1; s.rst = 1'b1; s.flush = 1'($urandom);
        apply(s, "rst_in_stall");
        s = rnd(); s.valid = 1'b1;
        apply(s, "load_after_rst");

        for (int i = 0; i < 400; i++) begin
            s = rnd();
            s.rst   = ($urandom_range(0, 31) == 0);
            s.flush = ($urandom_range(0, 7) == 0);
            s.stall = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0: s.wbrd = 5'd0;
                1: s.wbrd = s.rs1;
                2: s.wbrd = s.rs2;
                3: s.wbrd = model.rs1;
                default: s.wbrd = model.rs2;
            endcase
            apply(s, "random");
        end

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 5) begin
            @(posedge clk);
            #2;
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
